multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Sequencing FSM for the multi-cycle RV32I core, which reuses one ALU and one shared instruction/data memory across several cycles per instruction.
- Each cycle it drives the datapath's mux selects and write enables, and it handshakes with the shared memory.
- It also keeps retired-instruction and active-cycle counters, and latches fault flags.
- The datapath holds PC, OLD_PC, IR, MDR and ALUOut registers, plus the BranchComp comparator, which supplies branch_taken.

Parameters:
CNT_W, 32, width of instr_count and cycle_count
MAX_WAIT, 15, maximum cycles mem_req may stay unacknowledged before a fault; legal range 1..255

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
start  input  1  run enable; sampled only at instruction boundaries
opcode  input  7  IR[6:0]
branch_taken  input  1  BranchComp result for the current IR
mem_ready  input  1  memory acknowledges the current mem_req this cycle
mem_req  output  1  memory access request
mem_we  output  1  write access when 1
i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
ir_write  output  1  load IR and OLD_PC, with OLD_PC taking the current PC
pc_write  output  1  load PC
pc_src  output  1  PC source: 0 = ALU result, 1 = ALUOut register
reg_write  output  1  register file write enable
wb_sel  output  2  write-back source: 0 = ALUOut, 1 = MDR, 2 = PC
alu_src_a  output  2  ALU A: 0 = rs1, 1 = PC, 2 = OLD_PC
alu_src_b  output  2  ALU B: 0 = rs2, 1 = imm, 2 = constant 4
alu_op  output  2  00 = add, 01 = branch compare, 10 = funct-decoded
state  output  4  current state encoding, for debug
halted  output  1  FSM is in HALT
illegal  output  1  sticky flag: unsupported opcode was decoded
mem_fault  output  1  sticky flag: memory timeout occurred
instr_count  output  CNT_W  instructions retired
cycle_count  output  CNT_W  cycles spent outside IDLE and HALT

Behaviour:
- Reset (rst = 1 at a clk edge):
  - state = IDLE; both counters and both sticky flags are cleared.
  - All outputs are 0. Reset overrides every other condition, including in-flight memory requests.
- Default output value in any state is 0; each state drives only what is listed below.
- State encoding and transitions:
  - IDLE(0): go to FETCH when start = 1.
  - FETCH(1): mem_req = 1, i_or_d = 0.
    - When mem_ready = 1 (same cycle, Mealy): ir_write = 1, pc_write = 1, alu_src_a = 1, alu_src_b = 2, alu_op = 00, pc_src = 0 (PC <= PC + 4). Next state is DECODE.
    - Otherwise stay in FETCH.
  - DECODE(2): alu_src_a = 2, alu_src_b = 1, alu_op = 00 (ALUOut <= OLD_PC + imm). Next state by opcode:
    - 0110011 or 0010011 -> EXEC
    - 0000011 or 0100011 -> ADDR
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - any other opcode -> HALT with illegal <= 1
  - EXEC(3): alu_src_a = 0, alu_src_b = (opcode == 0010011) ? 1 : 0, alu_op = 10. Next state is WB_ALU.
  - WB_ALU(4): reg_write = 1, wb_sel = 0. Retires.
  - ADDR(5): alu_src_a = 0, alu_src_b = 1, alu_op = 00. Next state is MEM_RD for a load, MEM_WR for a store.
  - MEM_RD(6): mem_req = 1, i_or_d = 1. On mem_ready go to WB_MEM; the datapath captures MDR.
  - MEM_WR(7): mem_req = 1, mem_we = 1, i_or_d = 1. On mem_ready, retires.
  - WB_MEM(8): reg_write = 1, wb_sel = 1. Retires.
  - BRANCH(9): alu_src_a = 0, alu_src_b = 0, alu_op = 01, pc_src = 1, pc_write = branch_taken. Retires.
  - JAL(10): reg_write = 1, wb_sel = 2, pc_write = 1, pc_src = 1. Retires.
  - JALR(11): alu_src_a = 0, alu_src_b = 1, alu_op = 00, pc_write = 1, pc_src = 0, reg_write = 1, wb_sel = 2. The register file writes the old PC value (PC + 4); the datapath clears bit 0 of the target. Retires.
  - HALT(12): all control outputs 0; halted = 1. Exits only on rst.
- "Retires" means:
  - instr_count increments by 1.
  - Next state is FETCH if start = 1 in that cycle, otherwise IDLE.
- Latency with zero-wait memory (mem_ready = 1 in the request cycle), counted from FETCH entry:
  - R/I-type: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch, JAL, JALR: 3 cycles
- Memory timeout:
  - wait_cnt (8 bits) clears on entering FETCH, MEM_RD or MEM_WR.
  - It increments each cycle mem_req = 1 and mem_ready = 0.
  - When mem_ready = 0 and wait_cnt == MAX_WAIT - 1: next state is HALT and mem_fault <= 1.
  - If mem_ready = 1 arrives in that same cycle, the access succeeds and there is no fault.
- cycle_count:
  - Increments every cycle state is not IDLE and not HALT.
  - Both counters wrap modulo 2^CNT_W.
- start:
  - Ignored mid-instruction.
  - Dropping start never aborts an in-flight memory request.

Decomposition:
- Shared package mc_pkg holds:
  - the state enum;
  - opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR;
  - encodings for alu_op, wb_sel, alu_src_a and alu_src_b.
- One sub-module, mc_perf_counters, holds instr_count and cycle_count, driven by retire and active strobes. The FSM and timeout logic stay in the top module.

Test Plan:
- Reset and run: rst = 1 for 2 cycles, then start = 1, mem_ready = 1, IR = add (0x00208033). Required:
  - state sequence 0 -> 1 -> 2 -> 3 -> 4 -> 1;
  - reg_write pulses exactly once;
  - instr_count = 1 and cycle_count = 4 when state returns to 1.
- Load with wait states: lw, with mem_ready held low for 3 cycles in MEM_RD. Required:
  - mem_req = 1 and i_or_d = 1 held for 4 cycles;
  - WB_MEM asserts wb_sel = 1;
  - 8 cycles total from FETCH entry;
  - mem_fault = 0.
- Branch taken and not taken: beq with branch_taken = 1, then a second beq with branch_taken = 0. Required:
  - pc_write = 1 with pc_src = 1 in the first BRANCH cycle;
  - pc_write = 0 in the second;
  - 3 cycles each.
- JAL / JALR: in JAL, reg_write = 1, wb_sel = 2, pc_write = 1 and pc_src = 1 in one cycle. In JALR, the same but with pc_src = 0, alu_src_b = 1.
- Faults:
  - opcode 0x7F gives DECODE -> HALT, illegal = 1, halted = 1, and counters freeze.
  - mem_ready held low with MAX_WAIT = 15 gives HALT after 15 request cycles, with mem_fault = 1.
  - rst then clears both flags.
- Stop at boundary: deassert start during EXEC. Required: WB_ALU completes and retires, then state goes to IDLE with mem_req = 0. Reasserting start resumes in FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I sequencing FSM.
package mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_WB_ALU = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB_MEM = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_JALR   = 4'd11,
        S_HALT   = 4'd12
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_BR    = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    localparam logic [1:0] SRCA_RS1   = 2'd0;
    localparam logic [1:0] SRCA_PC    = 2'd1;
    localparam logic [1:0] SRCA_OLDPC = 2'd2;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

endpackage

// File: rtl/multicycle_control_if.sv
// Control/datapath/memory signal bundle; master = the control FSM, slave = datapath side.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    // Memory handshake: mem_req holds until a cycle with mem_ready = 1; that cycle completes the access.
    logic             start;
    logic [6:0]       opcode;
    logic             branch_taken;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             i_or_d;
    logic             ir_write;
    logic             pc_write;
    logic             pc_src;
    logic             reg_write;
    logic [1:0]       wb_sel;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [3:0]       state;
    logic             halted;
    logic             illegal;
    logic             mem_fault;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        input  start, opcode, branch_taken, mem_ready,
        output mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, reg_write,
               wb_sel, alu_src_a, alu_src_b, alu_op, state, halted, illegal,
               mem_fault, instr_count, cycle_count
    );

    modport slave (
        output start, opcode, branch_taken, mem_ready,
        input  mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, reg_write,
               wb_sel, alu_src_a, alu_src_b, alu_op, state, halted, illegal,
               mem_fault, instr_count, cycle_count
    );
endinterface

// File: rtl/mc_perf_counters.sv
// Retired-instruction and active-cycle counters; both wrap modulo 2^CNT_W.
module mc_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire_i,
    input  logic             active_i,
    output logic [CNT_W-1:0] instr_count_o,
    output logic [CNT_W-1:0] cycle_count_o
);
    logic [CNT_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;

    always_comb begin
        instr_d = instr_q;
        cycle_d = cycle_q;
        if (retire_i) instr_d = instr_q + 1'b1;
        if (active_i) cycle_d = cycle_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
            cycle_q <= '0;
        end else begin
            instr_q <= instr_d;
            cycle_q <= cycle_d;
        end
    end

    assign instr_count_o = instr_q;
    assign cycle_count_o = cycle_q;
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: drives datapath selects, handshakes memory, detects timeouts.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       illegal_q, illegal_d;
    logic       fault_q, fault_d;
    logic       retire;
    logic       active;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_d        = '0;
        illegal_d     = illegal_q;
        fault_d       = fault_q;
        retire        = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.i_or_d    = 1'b0;
        bus.ir_write  = 1'b0;
        bus.pc_write  = 1'b0;
        bus.pc_src    = 1'b0;
        bus.reg_write = 1'b0;
        bus.wb_sel    = WB_ALUOUT;
        bus.alu_src_a = SRCA_RS1;
        bus.alu_src_b = SRCB_RS2;
        bus.alu_op    = ALU_ADD;

        case (state_q)
            S_IDLE: if (bus.start) state_d = S_FETCH;
            S_FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_write  = 1'b1;
                    bus.pc_write  = 1'b1;
                    bus.alu_src_a = SRCA_PC;
                    bus.alu_src_b = SRCB_FOUR;
                    state_d       = S_DECODE;
                end
            end
            S_DECODE: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_IMM;
                case (bus.opcode)
                    OP_R, OP_I:        state_d = S_EXEC;
                    OP_LOAD, OP_STORE: state_d = S_ADDR;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                bus.alu_src_b = (bus.opcode == OP_I) ? SRCB_IMM : SRCB_RS2;
                bus.alu_op    = ALU_FUNCT;
                state_d       = S_WB_ALU;
            end
            S_WB_ALU: begin
                bus.reg_write = 1'b1;
                retire        = 1'b1;
            end
            S_ADDR: begin
                bus.alu_src_b = SRCB_IMM;
                state_d       = (bus.opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                bus.mem_req = 1'b1;
                bus.i_or_d  = 1'b1;
                if (bus.mem_ready) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                bus.i_or_d  = 1'b1;
                retire      = bus.mem_ready;
            end
            S_WB_MEM: begin
                bus.reg_write = 1'b1;
                bus.wb_sel    = WB_MDR;
                retire        = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_op   = ALU_BR;
                bus.pc_src   = 1'b1;
                bus.pc_write = bus.branch_taken;
                retire       = 1'b1;
            end
            S_JAL: begin
                bus.reg_write = 1'b1;
                bus.wb_sel    = WB_PC;
                bus.pc_write  = 1'b1;
                bus.pc_src    = 1'b1;
                retire        = 1'b1;
            end
            S_JALR: begin
                bus.alu_src_b = SRCB_IMM;
                bus.pc_write  = 1'b1;
                bus.reg_write = 1'b1;
                bus.wb_sel    = WB_PC;
                retire        = 1'b1;
            end
            default: ;
        endcase

        if (retire) state_d = bus.start ? S_FETCH : S_IDLE;

        // wait_q is zero whenever a memory state is entered, since every exit path leaves it cleared.
        if (bus.mem_req && !bus.mem_ready) begin
            if (wait_q == WAIT_LIMIT) begin
                state_d = S_HALT;
                fault_d = 1'b1;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end
    end

    assign active        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign bus.state     = state_q;
    assign bus.halted    = (state_q == S_HALT);
    assign bus.illegal   = illegal_q;
    assign bus.mem_fault = fault_q;

    mc_perf_counters #(.CNT_W(CNT_W)) u_perf (
        .clk           (clk),
        .rst           (rst),
        .retire_i      (retire),
        .active_i      (active),
        .instr_count_o (bus.instr_count),
        .cycle_count_o (bus.cycle_count)
    );
endmodule
